// File: rtl/me_frame_scheduler.sv
// Macroblock scheduler for a motion-estimation core: walks one frame in raster
// order, launches the core per macroblock, guards it with a watchdog and presents each result.
module me_frame_scheduler #(
  parameter int MB_COLS = 11,
  parameter int MB_ROWS = 9,
  parameter int TIMEOUT = 4096
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        frame_start,
  input  logic        me_ready,
  output logic        me_start,
  input  logic        me_valid,
  input  logic [15:0] me_min_sad,
  input  logic [5:0]  me_amt,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  out_mb_x,
  output logic [7:0]  out_mb_y,
  output logic [15:0] out_sad,
  output logic [5:0]  out_amt,
  output logic        busy,
  output logic        frame_done,
  output logic        err_timeout,
  output logic [2:0]  dbg_state
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LAUNCH = 3'd1;
  localparam logic [2:0] S_WAIT   = 3'd2;
  localparam logic [2:0] S_HOLD   = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  localparam logic [7:0]  LAST_X  = 8'(MB_COLS - 1);
  localparam logic [7:0]  LAST_Y  = 8'(MB_ROWS - 1);
  localparam logic [15:0] WD_LAST = 16'(TIMEOUT - 1);

  logic [2:0]  state;
  logic [15:0] wd;
  logic [7:0]  mb_x;
  logic [7:0]  mb_y;
  logic        valid_seen;

  // A result pulse in the same cycle as me_start belongs to an earlier job, so it is dropped.
  assign valid_seen = me_valid && (wd != 16'd0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      wd          <= 16'd0;
      mb_x        <= 8'd0;
      mb_y        <= 8'd0;
      out_sad     <= 16'd0;
      out_amt     <= 6'd0;
      err_timeout <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (frame_start) begin
            mb_x        <= 8'd0;
            mb_y        <= 8'd0;
            err_timeout <= 1'b0;
            state       <= S_LAUNCH;
          end
        end
        S_LAUNCH: begin
          if (me_ready) begin
            wd    <= 16'd0;
            state <= S_WAIT;
          end
        end
        S_WAIT: begin
          wd <= wd + 16'd1;
          if (valid_seen) begin
            out_sad <= me_min_sad;
            out_amt <= me_amt;
            state   <= S_HOLD;
          end else if (wd == WD_LAST) begin
            out_sad     <= 16'hFFFF;
            out_amt     <= 6'd0;
            err_timeout <= 1'b1;
            state       <= S_HOLD;
          end
        end
        // out_valid/out_ready: a result transfers on a cycle where both are high;
        // once out_valid rises the result stays unchanged until that cycle.
        S_HOLD: begin
          if (out_ready) begin
            if (mb_x == LAST_X) begin
              if (mb_y == LAST_Y) begin
                state <= S_DONE;
              end else begin
                mb_x  <= 8'd0;
                mb_y  <= mb_y + 8'd1;
                state <= S_LAUNCH;
              end
            end else begin
              mb_x  <= mb_x + 8'd1;
              state <= S_LAUNCH;
            end
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign me_start   = (state == S_WAIT) && (wd == 16'd0);
  assign out_valid  = (state == S_HOLD);
  assign busy       = (state != S_IDLE);
  assign frame_done = (state == S_DONE);
  assign out_mb_x   = mb_x;
  assign out_mb_y   = mb_y;
  assign dbg_state  = state;

endmodule

// File: tb/tb_me_frame_scheduler.sv
// Bench for me_frame_scheduler on a 2x2 frame with a 16-cycle watchdog: a vector
// table of core responses per macroblock plus hand-written stall/backpressure/reset sequences.
module tb_me_frame_scheduler;

  localparam int MB_COLS = 2;
  localparam int MB_ROWS = 2;
  localparam int TIMEOUT = 16;
  localparam int W       = 38;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        frame_start = 1'b0;
  logic        me_ready = 1'b1;
  logic        me_valid = 1'b0;
  logic [15:0] me_min_sad = 16'd0;
  logic [5:0]  me_amt = 6'd0;
  logic        out_ready = 1'b1;
  logic        me_start, out_valid, busy, frame_done, err_timeout;
  logic [7:0]  out_mb_x, out_mb_y;
  logic [15:0] out_sad;
  logic [5:0]  out_amt;
  logic [2:0]  dbg_state;

  int n_tests = 0;
  int n_fail = 0;
  int start_cnt = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] sb_exp;
  logic inject_fs = 1'b0;

  // delay: cycles from me_start to the result pulse, -1 = core never answers
  typedef struct {
    int          delay;
    bit          pre;
    logic [15:0] sad;
    logic [5:0]  amt;
    logic [7:0]  exp_x;
    logic [7:0]  exp_y;
    logic [15:0] exp_sad;
    logic [5:0]  exp_amt;
  } vec_t;

  vec_t vecs[12];
  vec_t to_vec;
  bit   frame_err[3];

  me_frame_scheduler #(.MB_COLS(MB_COLS), .MB_ROWS(MB_ROWS), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .me_ready(me_ready),
    .me_start(me_start), .me_valid(me_valid), .me_min_sad(me_min_sad), .me_amt(me_amt),
    .out_valid(out_valid), .out_ready(out_ready), .out_mb_x(out_mb_x), .out_mb_y(out_mb_y),
    .out_sad(out_sad), .out_amt(out_amt), .busy(busy), .frame_done(frame_done),
    .err_timeout(err_timeout), .dbg_state(dbg_state)
  );

  // clock / time limit
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL global_timeout: simulation did not finish in time");
    $fatal(1, "time limit");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] pack(input logic [7:0] x, input logic [7:0] y,
                                        input logic [15:0] s, input logic [5:0] a);
    return {x, y, s, a};
  endfunction

  // scoreboard / monitor, sampled 1 ns after the falling edge
  always @(negedge clk) begin
    #1;
    if (rst_n) begin
      if (me_start) start_cnt++;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL sb_unexpected: got result x=%0d y=%0d sad=0x%0h, expected none",
                   out_mb_x, out_mb_y, out_sad);
        end else begin
          sb_exp = exp_q.pop_front();
          check("sb_result", {out_mb_x, out_mb_y, out_sad, out_amt}, sb_exp);
        end
      end
    end
  end

  // driver tasks
  task automatic start_frame();
    @(negedge clk);
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
  endtask

  task automatic wait_start(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!me_start && n < 200);
    if (!me_start) begin
      n_tests++;
      n_fail++;
      $display("FAIL wait_start: me_start=0 after %0d cycles, expected a pulse", n);
    end
  endtask

  task automatic run_mb(input vec_t v, output int n);
    wait_start(n);
    exp_q.push_back(pack(v.exp_x, v.exp_y, v.exp_sad, v.exp_amt));
    me_valid   = v.pre;
    me_min_sad = 16'hDEAD;
    me_amt     = 6'h3F;
    @(negedge clk);
    me_valid    = 1'b0;
    frame_start = inject_fs;
    if (v.delay > 0) begin
      repeat (v.delay - 1) begin
        @(negedge clk);
        frame_start = 1'b0;
      end
      me_valid   = 1'b1;
      me_min_sad = v.sad;
      me_amt     = v.amt;
      @(negedge clk);
      me_valid    = 1'b0;
      frame_start = 1'b0;
    end else begin
      repeat (TIMEOUT - 2) begin
        @(negedge clk);
        frame_start = 1'b0;
      end
      check("timeout_not_early", out_valid, 0);
      @(negedge clk);
      check("timeout_hold_at_limit", out_valid, 1);
    end
  endtask

  task automatic finish_frame(input int s0, input bit exp_err);
    int n = 0;
    while (!frame_done && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("frame_done_seen", frame_done, 1);
    check("frame_err", err_timeout, exp_err);
    @(negedge clk);
    check("post_frame_idle", {frame_done, busy, out_valid}, 0);
    check("starts_per_frame", start_cnt - s0, MB_COLS * MB_ROWS);
    repeat (3) @(negedge clk);
    check("err_persists_idle", err_timeout, exp_err);
  endtask

  task automatic run_frame(input int base, input bit exp_err);
    int s0;
    int n;
    s0 = start_cnt;
    start_frame();
    check("err_cleared_on_start", err_timeout, 0);
    for (int r = 0; r < 4; r++) begin
      run_mb(vecs[base + r], n);
      if (r == 0) check("start_latency", n, 1);
    end
    finish_frame(s0, exp_err);
  endtask

  initial begin
    int s0;
    int n;

    vecs[0]  = '{10, 1'b0, 16'h0100, 6'd5,  8'd0, 8'd0, 16'h0100, 6'd5};
    vecs[1]  = '{10, 1'b0, 16'h0101, 6'd6,  8'd1, 8'd0, 16'h0101, 6'd6};
    vecs[2]  = '{10, 1'b0, 16'h0102, 6'd7,  8'd0, 8'd1, 16'h0102, 6'd7};
    vecs[3]  = '{10, 1'b0, 16'h0103, 6'd8,  8'd1, 8'd1, 16'h0103, 6'd8};
    vecs[4]  = '{1,  1'b0, 16'h0001, 6'h3F, 8'd0, 8'd0, 16'h0001, 6'h3F};
    vecs[5]  = '{15, 1'b0, 16'hFFFE, 6'h01, 8'd1, 8'd0, 16'hFFFE, 6'h01};
    vecs[6]  = '{-1, 1'b0, 16'h7777, 6'h11, 8'd0, 8'd1, 16'hFFFF, 6'h00};
    vecs[7]  = '{16, 1'b0, 16'h5555, 6'h22, 8'd1, 8'd1, 16'hFFFF, 6'h00};
    vecs[8]  = '{5,  1'b1, 16'h0BEE, 6'd7,  8'd0, 8'd0, 16'h0BEE, 6'd7};
    vecs[9]  = '{1,  1'b1, 16'h2222, 6'd9,  8'd1, 8'd0, 16'h2222, 6'd9};
    vecs[10] = '{2,  1'b0, 16'h0000, 6'd0,  8'd0, 8'd1, 16'h0000, 6'd0};
    vecs[11] = '{7,  1'b0, 16'h8000, 6'h2A, 8'd1, 8'd1, 16'h8000, 6'h2A};
    frame_err[0] = 1'b0;
    frame_err[1] = 1'b1;
    frame_err[2] = 1'b0;
    to_vec = '{-1, 1'b0, 16'h1111, 6'h01, 8'd0, 8'd0, 16'hFFFF, 6'h00};

    // reset state
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outputs",
          {me_start, out_valid, busy, frame_done, err_timeout, out_mb_x, out_mb_y, out_sad, out_amt}, 0);
    check("reset_state", dbg_state, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_after_reset", {busy, me_start, out_valid}, 0);

    // result pulse while idle changes nothing
    me_valid = 1'b1; me_min_sad = 16'h1234; me_amt = 6'h15;
    @(negedge clk);
    me_valid = 1'b0;
    @(negedge clk);
    check("idle_valid_ignored", {busy, dbg_state, out_sad, out_amt}, 0);

    // table-driven frames
    for (int f = 0; f < 3; f++) run_frame(f * 4, frame_err[f]);

    me_valid = 1'b1; me_min_sad = 16'h1234; me_amt = 6'h15;
    @(negedge clk);
    me_valid = 1'b0;
    @(negedge clk);
    check("idle_valid_keeps_data", {busy, out_sad, out_amt}, {1'b0, vecs[11].exp_sad, vecs[11].exp_amt});

    // core not ready: LAUNCH stalls, frame_start while busy is ignored
    me_ready = 1'b0;
    s0 = start_cnt;
    start_frame();
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      frame_start = (i == 10);
    end
    frame_start = 1'b0;
    check("launch_stall_no_start", start_cnt - s0, 0);
    check("launch_stall_state", {busy, dbg_state}, {1'b1, 3'd1});
    me_ready = 1'b1;
    run_mb(vecs[0], n);
    check("start_once_after_ready", start_cnt - s0, 1);
    inject_fs = 1'b1;
    run_mb(vecs[1], n);
    inject_fs = 1'b0;
    run_mb(vecs[2], n);
    run_mb(vecs[3], n);
    finish_frame(s0, 1'b0);

    // backpressure: result held for 20 cycles, no new launch
    out_ready = 1'b0;
    s0 = start_cnt;
    start_frame();
    run_mb(vecs[0], n);
    for (int i = 0; i < 20; i++) begin
      check("bp_hold_stable", {out_valid, out_mb_x, out_mb_y, out_sad, out_amt},
            {1'b1, vecs[0].exp_x, vecs[0].exp_y, vecs[0].exp_sad, vecs[0].exp_amt});
      @(negedge clk);
    end
    check("bp_no_start", start_cnt - s0, 1);
    out_ready = 1'b1;
    for (int r = 1; r < 4; r++) run_mb(vecs[r], n);
    finish_frame(s0, 1'b0);

    // reset while waiting on the core, after an earlier timeout
    start_frame();
    run_mb(to_vec, n);
    check("err_before_reset", err_timeout, 1);
    wait_start(n);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("midframe_reset_outputs",
          {me_start, out_valid, busy, frame_done, err_timeout, out_mb_x, out_mb_y, out_sad, out_amt}, 0);
    check("midframe_reset_state", dbg_state, 0);
    exp_q.delete();
    s0 = start_cnt;
    repeat (10) @(negedge clk);
    check("reset_no_start", start_cnt - s0, 0);
    run_frame(0, 1'b0);

    check("sb_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
